// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow input words into one wide output word.
//
// Input lanes are filled little-endian (first beat in lane 0). A word is
// emitted when all RATIO lanes are filled or when a beat carries inLast, in
// which case the unused upper lanes are zero and outKeep marks the filled
// lanes. The single-entry output register lets a new word load in the same
// cycle the previous one is taken, so throughput is one input beat per cycle
// while the consumer is ready.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   inValid   dIn / inLast valid
//   inReady   block accepts an input beat this cycle
//   dIn       input word, DATA_W bits
//   inLast    final word of the packet
//   outValid  dOut / outKeep / outLast valid
//   outReady  consumer ready
//   dOut      packed output word, DATA_W*RATIO bits
//   outKeep   per-lane valid mask, contiguous from bit 0
//   outLast   output word ends a packet

module stream_upsizer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RATIO  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [DATA_W-1:0]          dIn,
    input  logic                       inLast,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [DATA_W*RATIO-1:0]    dOut,
    output logic [RATIO-1:0]           outKeep,
    output logic                       outLast
);

    localparam int unsigned OUT_W = DATA_W * RATIO;
    localparam int unsigned CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;

    // Reject illegal parameter sets at elaboration, naming the instance.
    generate
        if (DATA_W < 1 || RATIO < 2) begin : gParamCheck
            $error("stream_upsizer %m: illegal parameters DATA_W=%0d RATIO=%0d (need DATA_W>=1, RATIO>=2)",
                   DATA_W, RATIO);
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [OUT_W-1:0]   acc;
    logic               rstDone;

    logic               inBeat;
    logic               outBeat;
    logic               complete;
    logic [OUT_W-1:0]   laneWord;
    logic [RATIO-1:0]   laneKeep;
    logic [OUT_W-1:0]   nextWord;

    // Held low through reset and the first edge after release.
    assign inReady = rstDone && (!outValid || outReady);

    // Handshakes, word completion and the word formed by the current beat.
    always_comb begin
        inBeat   = inValid && inReady;
        outBeat  = outValid && outReady;
        complete = inBeat && (inLast || (cnt == CNT_W'(RATIO - 1)));
        laneWord = '0;
        laneKeep = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) == cnt) begin
                laneWord[i*DATA_W +: DATA_W] = dIn;
            end
            // Lanes 0..cnt are written once the current beat lands.
            if (CNT_W'(i) <= cnt) begin
                laneKeep[i] = 1'b1;
            end
        end
        // Lanes above cnt are still zero in acc, so OR merges cleanly.
        nextWord = acc | laneWord;
    end

    // Reset-release tracker gating inReady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstDone <= 1'b0;
        end else begin
            rstDone <= 1'b1;
        end
    end

    // Lane accumulator and lane counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (inBeat) begin
            if (complete) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                acc <= nextWord;
            end
        end
    end

    // Output state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            outValid <= 1'b0;
            dOut     <= '0;
            outKeep  <= '0;
            outLast  <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (complete) begin
                        state    <= ST_FULL;
                        outValid <= 1'b1;
                        dOut     <= nextWord;
                        outKeep  <= laneKeep;
                        outLast  <= inLast;
                    end
                end
                ST_FULL: begin
                    // A completion here implies outReady, so the held word
                    // leaves on this edge and the new one replaces it.
                    if (complete) begin
                        state    <= ST_FULL;
                        outValid <= 1'b1;
                        dOut     <= nextWord;
                        outKeep  <= laneKeep;
                        outLast  <= inLast;
                    end else if (outBeat) begin
                        state    <= ST_EMPTY;
                        outValid <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_EMPTY;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
